// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder controller.
//   state_e      : controller state encoding (IDLE=0, ADD=1, DONE=2)
//   SliceDefault : default width of the shared carry-lookahead slice
package cla_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned SliceDefault = 4;

endpackage

// File: rtl/cla_slice.sv
// Combinational WIDTH-bit carry-lookahead adder slice.
// Ports:
//   x, y : operand slices
//   ci   : carry into bit 0
//   s    : slice sum
//   co   : carry out of the MSB
module cla_slice #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Each carry is expanded as a flat sum of generate/propagate products
  // rather than rippling from the previous carry.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(WIDTH); i++) begin
      logic acc;
      logic prod;
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & ci);
    end
  end

  assign s  = p ^ c[WIDTH-1:0];
  assign co = c[WIDTH];

endmodule

// File: rtl/cla_seq_add_ctrl.sv
// Sequential adder: one shared SLICE-bit carry-lookahead slice is reused
// over WIDTH/SLICE cycles, LSB slice first, to form {co,sum} = a + b + ci.
// WIDTH must be a multiple of SLICE.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin an addition (taken only when ready=1)
//   ready        : controller can accept start this cycle
//   a, b, ci     : operands and carry-in, captured on accept
//   sum, co      : registered result and final carry-out
//   done         : one-cycle pulse when sum/co become valid
module cla_seq_add_ctrl
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = SliceDefault
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             done
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             done_q, done_d;

  int unsigned      slice_base;
  logic [SLICE-1:0] op_x, op_y, slice_s;
  logic             slice_co;

  assign slice_base = int'(cnt_q) * SLICE;
  assign op_x       = a_q[slice_base +: SLICE];
  assign op_y       = b_q[slice_base +: SLICE];

  cla_slice #(
    .WIDTH(SLICE)
  ) u_slice (
    .x (op_x),
    .y (op_y),
    .ci(carry_q),
    .s (slice_s),
    .co(slice_co)
  );

  assign ready = (state_q != StAdd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    done_d  = 1'b0;

    unique case (state_q)
      StAdd: begin
        sum_d[slice_base +: SLICE] = slice_s;
        carry_d                    = slice_co;
        if (cnt_q == LastCnt) begin
          // Counter parks at the last slice; it restarts on the next accept.
          state_d = StDone;
          co_d    = slice_co;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle, StDone: begin
        if (start) begin
          state_d = StAdd;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign co   = co_q;
  assign done = done_q;

endmodule

// File: doc/cla_seq_add_ctrl.md
CLA_SEQ_ADD_CTRL -- requirements
Module: cla_seq_add_ctrl

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal only as a multiple of SLICE.
- REQ-002 SHALL have parameter SLICE, default 4, width of the shared carry-lookahead slice used per cycle.
- REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port start, input, 1, request to begin an addition; sampled only when ready=1.
- REQ-006 SHALL have port ready, output, 1, controller can accept start this cycle.
- REQ-007 SHALL have ports a and b, input, WIDTH each, operands; captured on accept.
- REQ-008 SHALL have port ci, input, 1, carry-in; captured on accept.
- REQ-009 SHALL have port sum, output, WIDTH, registered result.
- REQ-010 SHALL have port co, output, 1, registered carry out of the MSB slice.
- REQ-011 SHALL have port done, output, 1, one-cycle pulse marking valid sum/co.

Function
- REQ-012 SHALL implement states IDLE, ADD, DONE; N = WIDTH/SLICE; slice counter cnt, width clog2(N).
- REQ-013 SHALL drive ready=1 in IDLE and DONE, ready=0 in ADD.
- REQ-014 SHALL accept when start=1 and ready=1 at a rising edge (accept edge E0): capture a, b, ci into operand and carry registers; cnt=0; go to ADD.
- REQ-015 SHALL, in ADD, on each edge Ek (k=1..N), add operand slice cnt (LSB slice first) plus the carry register through the shared slice; write the slice sum into sum[cnt*SLICE +: SLICE]; load the slice carry-out into the carry register; increment cnt.
- REQ-016 SHALL transition ADD->DONE on edge EN (cnt==N-1), loading co with the final carry.
- REQ-017 SHALL assert done for exactly the cycle between EN and EN+1; done=0 in all other cycles.
- REQ-018 SHALL, in DONE, go to ADD on an accepting edge (back-to-back, throughput N+1 cycles per addition), otherwise to IDLE.
- REQ-019 SHALL ignore start while in ADD; captured operands and counter unaffected.
- REQ-020 SHALL ignore a, b, ci changes after accept.
- REQ-021 SHALL hold sum and co stable from done until the next accept edge; on accept, sum and co clear to 0.
- REQ-022 SHALL compute {co,sum} = a + b + ci modulo 2^(WIDTH+1); no saturation.
- REQ-023 SHALL restart cnt at 0 on every accept; cnt never wraps past N-1 inside ADD.

Reset
- REQ-024 SHALL, while reset_n=0, asynchronously force state=IDLE, cnt=0, carry register=0, operand registers=0, sum=0, co=0, done=0, ready=1.
- REQ-025 SHALL abort any in-progress addition on reset; no done is produced for it.
- REQ-026 SHALL accept start no earlier than the first rising edge after reset_n deasserts.

Structure
- REQ-027 SHALL take state encoding (IDLE=0, ADD=1, DONE=2) and SLICE default from a shared package cla_pkg.
- REQ-028 SHALL instantiate exactly one combinational sub-module cla_slice (SLICE-bit carry-lookahead adder: inputs x, y, ci; outputs s, co) as the shared datapath; no other adder in the block.

Verification
- REQ-029 SHALL cover a=0x1234, b=0x4321, ci=0 -> done 4 cycles after E0, sum=0x5555, co=0.
- REQ-030 SHALL cover a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1 (carry crosses all four slices).
- REQ-031 SHALL cover a=0xFFFF, b=0x0000, ci=1 -> sum=0x0000, co=1; and a=0x8000, b=0x8000, ci=0 -> sum=0x0000, co=1.
- REQ-032 SHALL cover start held high with new operands each accept -> accept every 5 cycles, each result correct, done pulses never merge.
- REQ-033 SHALL cover start=1 with a=0xAAAA during ADD of 0x0001+0x0001 -> ignored, result sum=0x0002, co=0.
- REQ-034 SHALL cover reset_n=0 during the second ADD cycle -> sum=0, co=0, done=0, ready=1 immediately; no done after release; next addition correct.
